axi_rr_arbiter: RTL and testbench

- Parametrised N-master to 1-slave AXI-lite arbiter between the core's bus masters (IFU, LSU, future DMA/debug) and the single memory/peripheral slave.
- Replaces the fixed two-master arbiter.
- Adds round-robin fairness, a configurable master count, and independent AW/W handshake ordering.
- Only one transaction (read or write) is outstanding at a time; the grant is held until that transaction's response handshake completes.

---
 rtl/axi_rr_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_rr_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axi_rr_arbiter.sv
// rtl/axi_rr_arbiter.sv - N-master to 1-slave AXI-lite round-robin arbiter
module axi_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int STRB_W      = 8,
    localparam int GW         = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_araddr,
    input  logic [NUM_MASTERS-1:0]        s_arvalid,
    input  logic [NUM_MASTERS-1:0]        s_rready,
    input  logic [NUM_MASTERS-1:0]        s_awvalid,
    input  logic [NUM_MASTERS-1:0]        s_wvalid,
    input  logic [NUM_MASTERS-1:0]        s_bready,
    input  logic [NUM_MASTERS*ADDR_W-1:0] s_awaddr,
    input  logic [NUM_MASTERS*DATA_W-1:0] s_wdata,
    input  logic [NUM_MASTERS*STRB_W-1:0] s_wstrb,
    output logic [NUM_MASTERS-1:0]        s_arready,
    output logic [NUM_MASTERS-1:0]        s_rvalid,
    output logic [NUM_MASTERS-1:0]        s_awready,
    output logic [NUM_MASTERS-1:0]        s_wready,
    output logic [NUM_MASTERS-1:0]        s_bvalid,
    output logic [DATA_W-1:0]             s_rdata,
    output logic [1:0]                    s_rresp,
    output logic [1:0]                    s_bresp,
    output logic [ADDR_W-1:0]             m_araddr,
    output logic [ADDR_W-1:0]             m_awaddr,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [STRB_W-1:0]             m_wstrb,
    output logic                          m_arvalid,
    output logic                          m_rready,
    output logic                          m_awvalid,
    output logic                          m_wvalid,
    output logic                          m_bready,
    input  logic                          m_arready,
    input  logic                          m_rvalid,
    input  logic                          m_awready,
    input  logic                          m_wready,
    input  logic                          m_bvalid,
    input  logic [DATA_W-1:0]             m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic [1:0]                    m_bresp,
    output logic [GW-1:0]                 grant_idx,
    output logic                          busy
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_XFER = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;

    logic [2:0]             state;
    logic [GW-1:0]          last_grant;
    logic                   aw_done;
    logic                   w_done;

    logic [NUM_MASTERS-1:0] req;
    logic                   any_req;
    logic [GW-1:0]          winner;
    logic                   win_rd;
    int                     idx;

    logic [ADDR_W-1:0]      g_araddr;
    logic [ADDR_W-1:0]      g_awaddr;
    logic [DATA_W-1:0]      g_wdata;
    logic [STRB_W-1:0]      g_wstrb;
    logic                   g_arvalid;
    logic                   g_rready;
    logic                   g_awvalid;
    logic                   g_wvalid;
    logic                   g_bready;

    logic                   in_rd_addr;
    logic                   in_rd_data;
    logic                   in_wr_xfer;
    logic                   in_wr_resp;
    logic                   ar_hs;
    logic                   rd_hs;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   b_hs;

    assign req = s_arvalid | s_awvalid;

    // Round-robin search starting one past the last master served
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        win_rd  = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            idx = int'(last_grant) + 1 + k;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!any_req && (j == idx) && req[j]) begin
                    any_req = 1'b1;
                    winner  = GW'(j);
                    win_rd  = s_arvalid[j];
                end
            end
        end
    end

    // Pick out the granted master's request-side signals
    always_comb begin
        g_araddr  = '0;
        g_awaddr  = '0;
        g_wdata   = '0;
        g_wstrb   = '0;
        g_arvalid = 1'b0;
        g_rready  = 1'b0;
        g_awvalid = 1'b0;
        g_wvalid  = 1'b0;
        g_bready  = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == GW'(i)) begin
                g_araddr  = s_araddr[i*ADDR_W +: ADDR_W];
                g_awaddr  = s_awaddr[i*ADDR_W +: ADDR_W];
                g_wdata   = s_wdata[i*DATA_W +: DATA_W];
                g_wstrb   = s_wstrb[i*STRB_W +: STRB_W];
                g_arvalid = s_arvalid[i];
                g_rready  = s_rready[i];
                g_awvalid = s_awvalid[i];
                g_wvalid  = s_wvalid[i];
                g_bready  = s_bready[i];
            end
        end
    end

    assign in_rd_addr = (state == RD_ADDR);
    assign in_rd_data = (state == RD_DATA);
    assign in_wr_xfer = (state == WR_XFER);
    assign in_wr_resp = (state == WR_RESP);
    assign busy       = (state != IDLE);

    // Slave-side outputs are zero outside the phase that owns them
    assign m_arvalid = in_rd_addr & g_arvalid;
    assign m_araddr  = in_rd_addr ? g_araddr : '0;
    assign m_rready  = in_rd_data & g_rready;
    assign m_awvalid = in_wr_xfer & g_awvalid & ~aw_done;
    assign m_wvalid  = in_wr_xfer & g_wvalid & ~w_done;
    assign m_awaddr  = in_wr_xfer ? g_awaddr : '0;
    assign m_wdata   = in_wr_xfer ? g_wdata : '0;
    assign m_wstrb   = in_wr_xfer ? g_wstrb : '0;
    assign m_bready  = in_wr_resp & g_bready;

    assign s_rdata = in_rd_data ? m_rdata : '0;
    assign s_rresp = in_rd_data ? m_rresp : 2'b00;
    assign s_bresp = in_wr_resp ? m_bresp : 2'b00;

    assign ar_hs = m_arvalid & m_arready;
    assign rd_hs = m_rready & m_rvalid;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bready & m_bvalid;

    // Route slave ready/valid back to the granted master only
    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_idx == GW'(i)) begin
                s_arready[i] = in_rd_addr & m_arready;
                s_rvalid[i]  = in_rd_data & m_rvalid;
                s_awready[i] = in_wr_xfer & m_awready & ~aw_done;
                s_wready[i]  = in_wr_xfer & m_wready & ~w_done;
                s_bvalid[i]  = in_wr_resp & m_bvalid;
            end
        end
    end

    // Transaction FSM; grant is held until the response handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_grant <= GW'(NUM_MASTERS - 1);
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_idx <= winner;
                        state     <= win_rd ? RD_ADDR : WR_XFER;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rd_hs) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                WR_XFER: begin
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        last_grant <= grant_idx;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// tb/tb_axi_rr_arbiter.sv - directed vector bench for axi_rr_arbiter with three masters
module tb_axi_rr_arbiter;

    localparam int N = 3;

    logic          clk;
    logic          rst;
    logic [N*32-1:0] s_araddr, s_awaddr, s_wdata;
    logic [N*8-1:0]  s_wstrb;
    logic [N-1:0]  s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [N-1:0]  s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [31:0]   s_rdata;
    logic [1:0]    s_rresp, s_bresp;
    logic [31:0]   m_araddr, m_awaddr, m_wdata;
    logic [7:0]    m_wstrb;
    logic          m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
    logic          m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
    logic [31:0]   m_rdata;
    logic [1:0]    m_rresp, m_bresp;
    logic [1:0]    grant_idx;
    logic          busy;

    axi_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(32), .DATA_W(32), .STRB_W(8)) dut (
        .clk(clk), .rst(rst),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_wvalid(s_wvalid), .s_bready(s_bready),
        .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_arready(s_arready), .s_rvalid(s_rvalid), .s_awready(s_awready),
        .s_wready(s_wready), .s_bvalid(s_bvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_bresp(s_bresp),
        .m_araddr(m_araddr), .m_awaddr(m_awaddr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_arvalid(m_arvalid), .m_rready(m_rready), .m_awvalid(m_awvalid),
        .m_wvalid(m_wvalid), .m_bready(m_bready),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_awready(m_awready),
        .m_wready(m_wready), .m_bvalid(m_bvalid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_bresp(m_bresp),
        .grant_idx(grant_idx), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       n;
        logic        r;
        logic [2:0]  arv, awv, wv, rr, br;
        logic [4:0]  sl;    // {arready, rvalid, awready, wready, bvalid}
        logic [31:0] rd;
        logic [1:0]  rrs, brs;
        logic        busy;
        logic [1:0]  g;
        logic [4:0]  m;     // {arvalid, awvalid, wvalid, rready, bready}
        logic [2:0]  sar, srv, saw, sw, sbv;
        logic [2:0]  dm;    // 0 none, 1 ar addr, 2 r data, 3 w xfer, 4 b resp
    } vec_t;

    logic [31:0] ar_tab [0:3];
    logic [31:0] aw_tab [0:3];
    logic [31:0] wd_tab [0:3];
    logic [7:0]  ws_tab [0:3];

    int checks   = 0;
    int failures = 0;
    vec_t tbl[$];

    function automatic vec_t v(input string n, input logic r,
                               input logic [2:0] arv, awv, wv, rr, br, input logic [4:0] sl,
                               input logic [31:0] rd, input logic [1:0] rrs, brs,
                               input logic eb, input logic [1:0] g, input logic [4:0] m,
                               input logic [2:0] sar, srv, saw, sw, sbv, input logic [2:0] dm);
        vec_t t;
        t.n = n; t.r = r; t.arv = arv; t.awv = awv; t.wv = wv; t.rr = rr; t.br = br;
        t.sl = sl; t.rd = rd; t.rrs = rrs; t.brs = brs; t.busy = eb; t.g = g; t.m = m;
        t.sar = sar; t.srv = srv; t.saw = saw; t.sw = sw; t.sbv = sbv; t.dm = dm;
        return t;
    endfunction

    task automatic step(input vec_t t);
        logic [22:0]  exp_c, act_c;
        logic [139:0] exp_d, act_d;
        logic [31:0]  e_ara, e_awa, e_wd, e_rd;
        logic [7:0]   e_ws;
        logic [1:0]   e_rr, e_br;
        rst = t.r;
        s_arvalid = t.arv; s_awvalid = t.awv; s_wvalid = t.wv; s_rready = t.rr; s_bready = t.br;
        m_arready = t.sl[4]; m_rvalid = t.sl[3]; m_awready = t.sl[2]; m_wready = t.sl[1];
        m_bvalid = t.sl[0]; m_rdata = t.rd; m_rresp = t.rrs; m_bresp = t.brs;
        #3;
        e_ara = '0; e_awa = '0; e_wd = '0; e_ws = '0; e_rd = '0; e_rr = '0; e_br = '0;
        case (t.dm)
            3'd1: e_ara = ar_tab[t.g];
            3'd2: begin e_rd = t.rd; e_rr = t.rrs; end
            3'd3: begin e_awa = aw_tab[t.g]; e_wd = wd_tab[t.g]; e_ws = ws_tab[t.g]; end
            3'd4: e_br = t.brs;
            default: ;
        endcase
        exp_c = {t.busy, t.g, t.m, t.sar, t.srv, t.saw, t.sw, t.sbv};
        act_c = {busy, grant_idx, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready,
                 s_arready, s_rvalid, s_awready, s_wready, s_bvalid};
        exp_d = {e_ara, e_awa, e_wd, e_ws, e_rd, e_rr, e_br};
        act_d = {m_araddr, m_awaddr, m_wdata, m_wstrb, s_rdata, s_rresp, s_bresp};
        checks++;
        if (act_c !== exp_c) begin
            failures++;
            $display("FAIL %s ctl actual=%h required=%h", t.n, act_c, exp_c);
        end
        checks++;
        if (act_d !== exp_d) begin
            failures++;
            $display("FAIL %s data actual=%h required=%h", t.n, act_d, exp_d);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        ar_tab[0] = 32'h8000_0000; ar_tab[1] = 32'h8000_1000; ar_tab[2] = 32'h8000_2000; ar_tab[3] = '0;
        aw_tab[0] = 32'ha000_0000; aw_tab[1] = 32'ha000_0048; aw_tab[2] = 32'ha000_0100; aw_tab[3] = '0;
        wd_tab[0] = 32'h1111_1111; wd_tab[1] = 32'hDEAD_BEEF; wd_tab[2] = 32'h2222_2222; wd_tab[3] = '0;
        ws_tab[0] = 8'hFF;         ws_tab[1] = 8'h0F;         ws_tab[2] = 8'h03;         ws_tab[3] = '0;
        s_araddr = {ar_tab[2], ar_tab[1], ar_tab[0]};
        s_awaddr = {aw_tab[2], aw_tab[1], aw_tab[0]};
        s_wdata  = {wd_tab[2], wd_tab[1], wd_tab[0]};
        s_wstrb  = {ws_tab[2], ws_tab[1], ws_tab[0]};
        rst = 1'b1;
        s_arvalid = '0; s_awvalid = '0; s_wvalid = '0; s_rready = '0; s_bready = '0;
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
        m_rdata = '0; m_rresp = '0; m_bresp = '0;

        // name, rst, arv, awv, wv, rr, br, slave, rdata, rresp, bresp,
        // busy, grant, m_ctl, s_arready, s_rvalid, s_awready, s_wready, s_bvalid, data mode
        tbl.push_back(v("reset_idle", 0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t1_idle",    0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t1_ar",      0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b10000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        tbl.push_back(v("t1_rwait",   0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b00010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2));
        tbl.push_back(v("t1_r",       0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 5'b01000, 32'h413, 2'd0, 2'd0, 1, 2'd0, 5'b00010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'd2));
        tbl.push_back(v("t1_done",    0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t2_idle1",   0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t2_ar1",     0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b10000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        tbl.push_back(v("t2_r1",      0, 3'b011, 3'b000, 3'b000, 3'b011, 3'b000, 5'b01000, 32'h1, 2'd0, 2'd0, 1, 2'd1, 5'b00010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'd2));
        tbl.push_back(v("t2_idle2",   0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t2_ar2",     0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b10000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        tbl.push_back(v("t2_r2",      0, 3'b011, 3'b000, 3'b000, 3'b011, 3'b000, 5'b01000, 32'h2, 2'd0, 2'd0, 1, 2'd0, 5'b00010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b000, 3'd2));
        tbl.push_back(v("t2_idle3",   0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t2_ar3",     0, 3'b011, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b10000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        tbl.push_back(v("t2_r3",      0, 3'b011, 3'b000, 3'b000, 3'b011, 3'b000, 5'b01000, 32'h3, 2'd0, 2'd0, 1, 2'd1, 5'b00010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'd2));
        tbl.push_back(v("t2_done",    0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t3_idle",    0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t3_w",       0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00010, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b01100, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'd3));
        tbl.push_back(v("t3_aw_wait", 0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b01000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd3));
        tbl.push_back(v("t3_aw",      0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00100, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b01000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'd3));
        tbl.push_back(v("t3_b_wait",  0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 5'b00000, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd4));
        tbl.push_back(v("t3_b",       0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 5'b00001, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b00001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'd4));
        tbl.push_back(v("t3_done",    0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t4_idle",    0, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t4_ar",      0, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b10000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        tbl.push_back(v("t4_r",       0, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 5'b01000, 32'h55, 2'd0, 2'd0, 1, 2'd1, 5'b00010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'd2));
        tbl.push_back(v("t4_idle2",   0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        tbl.push_back(v("t4_wr",      0, 3'b000, 3'b010, 3'b010, 3'b000, 3'b000, 5'b00110, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b01100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'd3));
        tbl.push_back(v("t4_b",       0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 5'b00001, 32'h0, 2'd0, 2'd1, 1, 2'd1, 5'b00001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'd4));
        tbl.push_back(v("t4_done",    0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Reset while waiting for read data, then a clean M1 read
        step(v("t5_idle",   0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        step(v("t5_ar",     0, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b10000, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        step(v("t5_rwait",  0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b00010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2));
        step(v("t5_rst",    1, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b00010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd2));
        step(v("t5_after",  0, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 5'b01000, 32'h99, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        step(v("t5_idle2",  0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        step(v("t5_ar2",    0, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b10000, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        step(v("t5_r2",     0, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 5'b01000, 32'hCAFE, 2'd0, 2'd0, 1, 2'd1, 5'b00010, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 3'd2));
        step(v("t5_done",   0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));

        // M2 read (DECERR passthrough) leaves last_grant=2, then all three request writes
        step(v("t6_idle",   0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        step(v("t6_ar",     0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 5'b10000, 32'h0, 2'd0, 2'd0, 1, 2'd2, 5'b10000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'd1));
        step(v("t6_r",      0, 3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 5'b01000, 32'h7, 2'd3, 2'd0, 1, 2'd2, 5'b00010, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'd2));
        step(v("t6_idle2",  0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd2, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        step(v("t6_wr",     0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 5'b00110, 32'h0, 2'd0, 2'd0, 1, 2'd0, 5'b01100, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'd3));
        step(v("t6_b",      0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b111, 5'b00001, 32'h0, 2'd0, 2'd2, 1, 2'd0, 5'b00001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'd4));
        step(v("t6_idle3",  0, 3'b000, 3'b110, 3'b110, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));
        step(v("t6_wr2",    0, 3'b000, 3'b110, 3'b110, 3'b000, 3'b000, 5'b00110, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b01100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000, 3'd3));
        step(v("t6_b2",     0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b110, 5'b00001, 32'h0, 2'd0, 2'd0, 1, 2'd1, 5'b00001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'd4));
        step(v("t6_done",   0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 5'b00000, 32'h0, 2'd0, 2'd0, 0, 2'd1, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'd0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
